// File: rtl/ticket_window_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ticket_pkg
// Shared definitions for the ticket window arbiter:
//   state_t           sequencer states (IDLE, LATCH, PRICE, COLLECT, SETTLE)
//   UNIT_FARE_DEF     default TWD charged per station spanned
//   MONEY_W_DEF       default width of money values
//   sat_add()         saturating adder for money values up to 32 bits wide
// ---------------------------------------------------------------------------
package ticket_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LATCH   = 3'd1,
        PRICE   = 3'd2,
        COLLECT = 3'd3,
        SETTLE  = 3'd4
    } state_t;

    localparam int UNIT_FARE_DEF = 5;
    localparam int MONEY_W_DEF   = 16;

    // Adds a + b and clamps the result to max_val. Operands are carried in
    // 32 bits so the same helper serves any money width up to 32.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_val
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/ticket_window_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Returns the first asserted request at
// or after the pointer, wrapping cyclically past the last window.
// Ports:
//   req    in  NUM_WIN  request vector
//   ptr    in  IDX_W    highest-priority window index (must be < NUM_WIN)
//   gnt    out NUM_WIN  one-hot winner (all zero when valid is low)
//   idx    out IDX_W    winner index
//   valid  out 1        any request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_WIN = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_WIN-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_WIN-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // cand[k] is the window that sits k places after the pointer.
    logic [IDX_W-1:0]   cand [NUM_WIN];
    logic [NUM_WIN-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WIN; gi++) begin : g_cand
            logic [IDX_W:0] sum_w;
            assign sum_w = {1'b0, ptr} + (IDX_W+1)'(gi);
            // ptr and gi are both below NUM_WIN, so one subtraction wraps.
            assign cand[gi] = (sum_w >= (IDX_W+1)'(NUM_WIN))
                            ? IDX_W'(sum_w - (IDX_W+1)'(NUM_WIN))
                            : sum_w[IDX_W-1:0];
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Lowest offset wins: walk from the far end so the nearest hit is last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_WIN - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ticket_window_arbiter.sv
// ---------------------------------------------------------------------------
// ticket_window_arbiter
// Shares one fare/settlement engine among NUM_WIN ticket windows. A window is
// chosen round-robin, its trip is latched and priced, coins are collected,
// and the transaction settles with tickets + change or a full refund.
//
// Optional feature macro: TICKET_TIMEOUT_EN
//   When defined, a COLLECT idle-payment counter cancels the transaction
//   after TIMEOUT_CYC cycles without an accepted coin and the extra output
//   timed_out pulses together with that refund's done.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   req         in   per-window request level
//   src_st      in   packed source stations   (window i at [i*ST_W +: ST_W])
//   dst_st      in   packed destination stations
//   tkt_num     in   packed ticket counts     (window i at [i*NUM_W +: NUM_W])
//   coin_valid  in   per-window one-cycle coin strobe
//   coin_val    in   packed coin values       (window i at [i*MONEY_W +: MONEY_W])
//   cancel      in   per-window one-cycle cancel strobe
//   grant       out  one-hot engine owner, LATCH through SETTLE
//   busy        out  sequencer not in IDLE
//   price       out  total fare of the current transaction
//   paid        out  accumulated payment
//   done        out  one-cycle settlement pulse
//   done_win    out  index of the settled window
//   out_num     out  tickets issued (held until next done)
//   out_cash    out  change or refund (held until next done)
//   cancelled   out  done is a refund
//   timed_out   out  (TICKET_TIMEOUT_EN only) done was caused by timeout
// MONEY_W must not exceed 32.
// ---------------------------------------------------------------------------
module ticket_window_arbiter
    import ticket_pkg::*;
#(
    parameter int NUM_WIN     = 4,
    parameter int ST_W        = 4,
    parameter int NUM_W       = 4,
    parameter int MONEY_W     = MONEY_W_DEF,
    parameter int UNIT_FARE   = UNIT_FARE_DEF
`ifdef TICKET_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000
`endif
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_WIN-1:0]         req,
    input  logic [NUM_WIN*ST_W-1:0]    src_st,
    input  logic [NUM_WIN*ST_W-1:0]    dst_st,
    input  logic [NUM_WIN*NUM_W-1:0]   tkt_num,
    input  logic [NUM_WIN-1:0]         coin_valid,
    input  logic [NUM_WIN*MONEY_W-1:0] coin_val,
    input  logic [NUM_WIN-1:0]         cancel,
    output logic [NUM_WIN-1:0]         grant,
    output logic                       busy,
    output logic [MONEY_W-1:0]         price,
    output logic [MONEY_W-1:0]         paid,
    output logic                       done,
    output logic [2:0]                 done_win,
    output logic [NUM_W-1:0]           out_num,
    output logic [MONEY_W-1:0]         out_cash,
    output logic                       cancelled
`ifdef TICKET_TIMEOUT_EN
    ,
    output logic                       timed_out
`endif
);

    localparam int IDX_W  = $clog2(NUM_WIN);
    // Wide enough for UNIT_FARE * span * num without any overflow.
    localparam int PROD_W = 32 + ST_W + 1 + NUM_W;
    localparam logic [MONEY_W-1:0] MONEY_MAX = '1;

    // ---------------- state ----------------
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [NUM_WIN-1:0]   gnt_q, gnt_d;
    logic [ST_W-1:0]      src_q, src_d;
    logic [ST_W-1:0]      dst_q, dst_d;
    logic [NUM_W-1:0]     num_q, num_d;
    logic [MONEY_W-1:0]   price_q, price_d;
    logic [MONEY_W-1:0]   paid_q, paid_d;
    logic [NUM_W-1:0]     out_num_q, out_num_d;
    logic [MONEY_W-1:0]   out_cash_q, out_cash_d;
    logic                 cancelled_q, cancelled_d;
    logic [2:0]           done_win_q, done_win_d;

    // ---------------- selection ----------------
    logic [NUM_WIN-1:0]   pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    rr_pick #(
        .NUM_WIN (NUM_WIN),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // ---------------- granted-window views ----------------
    logic [ST_W-1:0]      sel_src, sel_dst;
    logic [NUM_W-1:0]     sel_num;
    logic [MONEY_W-1:0]   sel_coin;
    logic                 coin_hit;
    logic                 user_abort;

    assign sel_src    = src_st[int'(win_q)*ST_W +: ST_W];
    assign sel_dst    = dst_st[int'(win_q)*ST_W +: ST_W];
    assign sel_num    = tkt_num[int'(win_q)*NUM_W +: NUM_W];
    assign sel_coin   = coin_val[int'(win_q)*MONEY_W +: MONEY_W];
    assign coin_hit   = coin_valid[win_q];
    // Dropping req while paying is treated exactly like a cancel.
    assign user_abort = cancel[win_q] | ~req[win_q];

    // ---------------- fare ----------------
    logic [ST_W-1:0]      diff;
    logic [ST_W:0]        span;
    logic [PROD_W-1:0]    fare_full;
    logic [MONEY_W-1:0]   fare_sat;

    assign diff      = (src_q > dst_q) ? (src_q - dst_q) : (dst_q - src_q);
    assign span      = {1'b0, diff} + 1'b1;
    assign fare_full = PROD_W'(UNIT_FARE) * PROD_W'(span) * PROD_W'(num_q);
    assign fare_sat  = (fare_full > PROD_W'(MONEY_MAX)) ? MONEY_MAX
                                                        : fare_full[MONEY_W-1:0];

    // ---------------- payment ----------------
    logic [MONEY_W-1:0]   paid_new;
    logic                 paid_enough;
    logic                 abort;
    logic                 tmo_hit;

    // The coin is always added before a same-cycle cancel is acted on, so a
    // coin arriving with cancel ends up in the refund.
    assign paid_new    = coin_hit
                       ? MONEY_W'(sat_add(32'(paid_q), 32'(sel_coin), 32'(MONEY_MAX)))
                       : paid_q;
    assign paid_enough = (paid_new >= price_q);
    assign abort       = user_abort | tmo_hit;

`ifdef TICKET_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_flag_q, tmo_flag_d;

    // The cycle that would bring the count to TIMEOUT_CYC is the timeout.
    assign tmo_hit = (state_q == COLLECT) && !coin_hit &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        tmo_flag_d = tmo_flag_q;
        if (state_q == PRICE) begin
            tmo_cnt_d = '0;
        end else if (state_q == COLLECT) begin
            tmo_cnt_d = coin_hit ? '0 : tmo_cnt_q + 1'b1;
        end
        // The flag is refreshed on every entry to SETTLE, alongside out_*.
        if (state_q == PRICE && num_q == '0) begin
            tmo_flag_d = 1'b0;
        end else if (state_q == COLLECT && (abort || paid_enough)) begin
            tmo_flag_d = tmo_hit && !user_abort;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = LATCH;
            LATCH:   state_d = PRICE;
            PRICE:   state_d = (num_q == '0) ? SETTLE : COLLECT;
            COLLECT: if (abort || paid_enough) state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        ptr_d       = ptr_q;
        win_d       = win_q;
        gnt_d       = gnt_q;
        src_d       = src_q;
        dst_d       = dst_q;
        num_d       = num_q;
        price_d     = price_q;
        paid_d      = paid_q;
        out_num_d   = out_num_q;
        out_cash_d  = out_cash_q;
        cancelled_d = cancelled_q;
        done_win_d  = done_win_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d = pick_idx;
                    gnt_d = pick_gnt;
                end
            end
            LATCH: begin
                src_d = sel_src;
                dst_d = sel_dst;
                num_d = sel_num;
            end
            PRICE: begin
                price_d = fare_sat;
                paid_d  = '0;
                if (num_q == '0) begin
                    // Zero-ticket order settles as an empty refund.
                    out_num_d   = '0;
                    out_cash_d  = '0;
                    cancelled_d = 1'b1;
                    done_win_d  = 3'(win_q);
                end
            end
            COLLECT: begin
                paid_d = paid_new;
                if (abort) begin
                    out_num_d   = '0;
                    out_cash_d  = paid_new;
                    cancelled_d = 1'b1;
                    done_win_d  = 3'(win_q);
                end else if (paid_enough) begin
                    out_num_d   = num_q;
                    out_cash_d  = paid_new - price_q;
                    cancelled_d = 1'b0;
                    done_win_d  = 3'(win_q);
                end
            end
            SETTLE: begin
                // Served window moves to the back of the rotation.
                ptr_d = (win_q == IDX_W'(NUM_WIN - 1)) ? '0 : win_q + 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            gnt_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            num_q       <= '0;
            price_q     <= '0;
            paid_q      <= '0;
            out_num_q   <= '0;
            out_cash_q  <= '0;
            cancelled_q <= 1'b0;
            done_win_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            num_q       <= num_d;
            price_q     <= price_d;
            paid_q      <= paid_d;
            out_num_q   <= out_num_d;
            out_cash_q  <= out_cash_d;
            cancelled_q <= cancelled_d;
            done_win_q  <= done_win_d;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == SETTLE);
        grant = busy ? gnt_q : '0;
`ifdef TICKET_TIMEOUT_EN
        timed_out = done && tmo_flag_q;
`endif
    end

    assign price     = price_q;
    assign paid      = paid_q;
    assign done_win  = done_win_q;
    assign out_num   = out_num_q;
    assign out_cash  = out_cash_q;
    assign cancelled = cancelled_q;

endmodule

// File: tb/tb_ticket_window_arbiter.sv
module tb_ticket_window_arbiter;

    localparam int NUM_WIN = 4;
    localparam int ST_W    = 4;
    localparam int NUM_W   = 4;
    localparam int MONEY_W = 16;

    logic                       clock;
    logic                       reset;
    logic [NUM_WIN-1:0]         req;
    logic [NUM_WIN*ST_W-1:0]    src_st;
    logic [NUM_WIN*ST_W-1:0]    dst_st;
    logic [NUM_WIN*NUM_W-1:0]   tkt_num;
    logic [NUM_WIN-1:0]         coin_valid;
    logic [NUM_WIN*MONEY_W-1:0] coin_val;
    logic [NUM_WIN-1:0]         cancel;
    logic [NUM_WIN-1:0]         grant;
    logic                       busy;
    logic [MONEY_W-1:0]         price;
    logic [MONEY_W-1:0]         paid;
    logic                       done;
    logic [2:0]                 done_win;
    logic [NUM_W-1:0]           out_num;
    logic [MONEY_W-1:0]         out_cash;
    logic                       cancelled;
`ifdef TICKET_TIMEOUT_EN
    logic                       timed_out;
`endif

    int vectors     = 0;
    int miscompares = 0;

    ticket_window_arbiter #(
        .NUM_WIN     (NUM_WIN),
        .ST_W        (ST_W),
        .NUM_W       (NUM_W),
        .MONEY_W     (MONEY_W),
        .UNIT_FARE   (5)
`ifdef TICKET_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .src_st     (src_st),
        .dst_st     (dst_st),
        .tkt_num    (tkt_num),
        .coin_valid (coin_valid),
        .coin_val   (coin_val),
        .cancel     (cancel),
        .grant      (grant),
        .busy       (busy),
        .price      (price),
        .paid       (paid),
        .done       (done),
        .done_win   (done_win),
        .out_num    (out_num),
        .out_cash   (out_cash),
        .cancelled  (cancelled)
`ifdef TICKET_TIMEOUT_EN
        ,
        .timed_out  (timed_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0d exp=%0d", vectors, tag, obs, exp);
    endtask

    task automatic set_trip(input int w, input int s, input int d, input int n);
        src_st[w*ST_W +: ST_W]   = ST_W'(s);
        dst_st[w*ST_W +: ST_W]   = ST_W'(d);
        tkt_num[w*NUM_W +: NUM_W] = NUM_W'(n);
    endtask

    // One coin strobe (optionally with cancel) lasting one clock.
    task automatic coin_step(input int w, input int v, input logic with_cancel);
        coin_valid[w]                 = 1'b1;
        coin_val[w*MONEY_W +: MONEY_W] = MONEY_W'(v);
        cancel[w]                     = with_cancel;
        tick();
        coin_valid = '0;
        cancel     = '0;
    endtask

    initial begin
        reset      = 1'b0;
        req        = '0;
        src_st     = '0;
        dst_st     = '0;
        tkt_num    = '0;
        coin_valid = '0;
        coin_val   = '0;
        cancel     = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Reset state
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_price", 32'(price), 0);
        chk("rst_paid", 32'(paid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_out_num", 32'(out_num), 0);
        chk("rst_out_cash", 32'(out_cash), 0);
        chk("rst_cancelled", 32'(cancelled), 0);

        // Window 0: 2->5, 3 tickets = 5*4*3 = 60; pay 50 + 20
        set_trip(0, 2, 5, 3);
        req = 4'b0001;
        tick();
        chk("t1_latch_grant", 32'(grant), 32'b0001);
        chk("t1_latch_busy", 32'(busy), 1);
        tick();
        tick();
        chk("t1_price", 32'(price), 60);
        chk("t1_paid_clr", 32'(paid), 0);
        coin_step(0, 50, 1'b0);
        chk("t1_paid50", 32'(paid), 50);
        chk("t1_no_done", 32'(done), 0);
        coin_step(0, 20, 1'b0);
        chk("t1_done", 32'(done), 1);
        chk("t1_done_win", 32'(done_win), 0);
        chk("t1_out_num", 32'(out_num), 3);
        chk("t1_out_cash", 32'(out_cash), 10);
        chk("t1_cancelled", 32'(cancelled), 0);
        chk("t1_settle_grant", 32'(grant), 32'b0001);
        req = '0;
        tick();
        chk("t1_done_drop", 32'(done), 0);
        chk("t1_grant_drop", 32'(grant), 0);
        chk("t1_out_num_hold", 32'(out_num), 3);

        // Window 1: 7->1, 1 ticket = 35; stray coin on window 3 ignored
        set_trip(1, 7, 1, 1);
        req = 4'b0010;
        repeat (3) tick();
        chk("t2_price", 32'(price), 35);
        chk("t2_grant", 32'(grant), 32'b0010);
        coin_step(3, 100, 1'b0);
        chk("t2_stray_paid", 32'(paid), 0);
        chk("t2_stray_busy", 32'(busy), 1);
        coin_step(1, 35, 1'b0);
        chk("t2_done", 32'(done), 1);
        chk("t2_done_win", 32'(done_win), 1);
        chk("t2_out_cash", 32'(out_cash), 0);
        chk("t2_out_num", 32'(out_num), 1);
        req = '0;
        tick();

        // Fresh reset, then req=0101: window 0, then window 2, then window 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_trip(0, 0, 0, 1);   // 5
        set_trip(2, 3, 0, 2);   // 5*4*2 = 40
        req = 4'b0101;
        tick();
        chk("t3_first_grant", 32'(grant), 32'b0001);
        tick();
        tick();
        chk("t3_w0_price", 32'(price), 5);
        coin_step(0, 5, 1'b0);
        chk("t3_w0_done_win", 32'(done_win), 0);
        tick();
        chk("t3_idle_grant", 32'(grant), 0);
        tick();
        chk("t3_second_grant", 32'(grant), 32'b0100);
        tick();
        tick();
        chk("t3_w2_price", 32'(price), 40);
        coin_step(2, 30, 1'b0);
        chk("t3_w2_paid30", 32'(paid), 30);
        coin_step(2, 10, 1'b1);
        chk("t4_done", 32'(done), 1);
        chk("t4_cancelled", 32'(cancelled), 1);
        chk("t4_out_num", 32'(out_num), 0);
        chk("t4_out_cash", 32'(out_cash), 40);
        chk("t4_done_win", 32'(done_win), 2);
        tick();
        set_trip(0, 0, 9, 1);   // 5*10 = 50
        tick();
        chk("t3_wrap_grant", 32'(grant), 32'b0001);

        // Asynchronous reset in COLLECT with paid = 25
        req = 4'b0001;
        tick();
        tick();
        chk("t5_price", 32'(price), 50);
        coin_step(0, 25, 1'b0);
        chk("t5_paid25", 32'(paid), 25);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(grant), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_price", 32'(price), 0);
        chk("t5_rst_paid", 32'(paid), 0);
        chk("t5_rst_done", 32'(done), 0);
        chk("t5_rst_out_cash", 32'(out_cash), 0);
        chk("t5_rst_cancelled", 32'(cancelled), 0);
        tick();
        chk("t5_rst_no_done", 32'(done), 0);
        reset = 1'b1;
        tick();
        chk("t5_restart_grant", 32'(grant), 32'b0001);
        chk("t5_restart_paid", 32'(paid), 0);
        tick();
        tick();
        chk("t5_restart_price", 32'(price), 50);
        chk("t5_restart_paid0", 32'(paid), 0);

        // Dropping req in COLLECT refunds as a cancel
        req = '0;
        tick();
        chk("t6_drop_done", 32'(done), 1);
        chk("t6_drop_cancelled", 32'(cancelled), 1);
        chk("t6_drop_cash", 32'(out_cash), 0);
        tick();

        // Zero tickets: PRICE straight to SETTLE as cancelled
        set_trip(3, 4, 6, 0);
        req = 4'b1000;
        tick();
        chk("t7_grant", 32'(grant), 32'b1000);
        tick();
        tick();
        chk("t7_done", 32'(done), 1);
        chk("t7_cancelled", 32'(cancelled), 1);
        chk("t7_price", 32'(price), 0);
        chk("t7_done_win", 32'(done_win), 3);
        chk("t7_out_num", 32'(out_num), 0);
        req = '0;
        tick();

`ifdef TICKET_TIMEOUT_EN
        // Timeout: price 20, coin 5, then 8 idle cycles
        set_trip(1, 1, 2, 2);
        req = 4'b0010;
        repeat (3) tick();
        chk("t8_price", 32'(price), 20);
        coin_step(1, 5, 1'b0);
        chk("t8_paid", 32'(paid), 5);
        repeat (7) tick();
        chk("t8_not_yet", 32'(done), 0);
        tick();
        chk("t8_done", 32'(done), 1);
        chk("t8_timed_out", 32'(timed_out), 1);
        chk("t8_cancelled", 32'(cancelled), 1);
        chk("t8_out_cash", 32'(out_cash), 5);
        req = '0;
        tick();
        chk("t8_pulse_end", 32'(timed_out), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
